// File: rtl/gomoku_pkg.sv
// Shared encodings for the gomoku match controller: states, sides, judger
// result codes and board cell codes.
package gomoku_pkg;

    typedef enum logic [3:0] {
        S_STOPPED     = 4'd0,
        S_STARTING    = 4'd1,
        S_RESET_STATE = 4'd2,
        S_WAIT_INPUT  = 4'd3,
        S_JUDGE       = 4'd4,
        S_WRITE       = 4'd5,
        S_UNDO        = 4'd6,
        S_END         = 4'd7,
        S_MATCH_END   = 4'd8
    } state_e;

    localparam logic SIDE_RED   = 1'b0;
    localparam logic SIDE_GREEN = 1'b1;

    // Must track game_judger's result encoding.
    localparam logic [1:0] JUDGER_INVALID = 2'b00;
    localparam logic [1:0] JUDGER_VALID   = 2'b01;
    localparam logic [1:0] JUDGER_WIN     = 2'b10;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_RED   = 2'b01;
    localparam logic [1:0] CELL_GREEN = 2'b10;

    function automatic logic [1:0] side_cell(input logic side);
        return (side == SIDE_RED) ? CELL_RED : CELL_GREEN;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: reloads on load or after expiring, decrements on tick,
// and is held at zero while disabled.
module turn_timer #(
    parameter int unsigned RELOAD = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic       tick,
    output logic [3:0] count,
    output logic       expire
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!en) begin
            count_d = 4'd0;
        end else if (load) begin
            count_d = 4'(RELOAD);
        end else if (tick) begin
            count_d = (count_q == 4'd0) ? 4'(RELOAD) : count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Independent of en/load so the controller can use it to pick its next state.
    assign expire = tick & (count_q == 4'd0);
    assign count  = count_q;

endmodule

// File: rtl/gomoku_match_ctrl.sv
// Match controller for an N x N gomoku board: power-up, board clear, key
// entry, judging, board write, undo, turn timeout and match-point tracking.
module gomoku_match_ctrl
    import gomoku_pkg::*;
#(
    parameter int unsigned EDGE_BITS    = 3,
    parameter int unsigned TURN_SECONDS = 9,
    parameter int unsigned WIN_BITS     = 4,
    parameter int unsigned MATCH_POINT  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_power,
    input  logic                   btn_reset,
    input  logic                   btn_ok,
    input  logic                   btn_undo,
    input  logic                   tick,
    input  logic                   flicker_fall,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [EDGE_BITS:0]     key_index,
    output logic                   memrst_en,
    input  logic                   memrst_done,
    output logic                   judge_req,
    input  logic                   judge_done,
    input  logic [1:0]             judge_result,
    output logic [2*EDGE_BITS-1:0] pos,
    output logic                   active_side,
    output logic                   ram_we,
    output logic [1:0]             ram_wr_data,
    output logic                   cursor_valid,
    output logic [3:0]             num_countdown,
    output logic [WIN_BITS-1:0]    red_wins,
    output logic [WIN_BITS-1:0]    green_wins,
    output logic [3:0]             state_o,
    output logic                   match_over
);

    localparam int unsigned PB = 2 * EDGE_BITS;
    localparam int unsigned CB = PB + 1;
    localparam logic [CB-1:0]       LAST_CELL = CB'((1 << PB) - 1);
    localparam logic [WIN_BITS-1:0] WIN_MAX   = '1;
    localparam logic [WIN_BITS-1:0] MP_VAL    = WIN_BITS'(MATCH_POINT);

    state_e                state_q, state_d;
    logic                  side_q, side_d;
    logic                  loser_q, loser_d;
    logic [EDGE_BITS-1:0]  x_q, x_d, y_q, y_d;
    logic                  x_ent_q, x_ent_d, y_ent_q, y_ent_d;
    logic                  undo_q, undo_d;
    logic [PB-1:0]         last_pos_q, last_pos_d;
    logic [CB-1:0]         pieces_q, pieces_d;
    logic [WIN_BITS-1:0]   red_q, red_d, green_q, green_d;
    logic [1:0]            flick_q, flick_d;
    logic [1:0]            result_q, result_d;
    logic                  ok_prev_q, ok_prev_d, undo_prev_q, undo_prev_d;

    logic                  ok_rise, undo_rise;
    logic                  timer_en, timer_load, timer_expire;
    logic [PB-1:0]         cur_pos;
    logic [WIN_BITS-1:0]   red_inc, green_inc;

    assign ok_rise   = btn_ok & ~ok_prev_q;
    assign undo_rise = btn_undo & ~undo_prev_q;
    assign cur_pos   = {y_q, x_q};
    assign red_inc   = (red_q == WIN_MAX) ? red_q : red_q + 1'b1;
    assign green_inc = (green_q == WIN_MAX) ? green_q : green_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        side_d      = side_q;
        loser_d     = loser_q;
        x_d         = x_q;
        y_d         = y_q;
        x_ent_d     = x_ent_q;
        y_ent_d     = y_ent_q;
        undo_d      = undo_q;
        last_pos_d  = last_pos_q;
        pieces_d    = pieces_q;
        red_d       = red_q;
        green_d     = green_q;
        flick_d     = 2'd0;
        result_d    = result_q;
        ok_prev_d   = btn_ok;
        undo_prev_d = btn_undo;

        // Key capture sits before the FSM so any clear below takes precedence.
        if (key_valid && key_ready) begin
            if (key_index[EDGE_BITS]) begin
                x_d     = key_index[EDGE_BITS-1:0];
                x_ent_d = 1'b1;
            end else begin
                y_d     = key_index[EDGE_BITS-1:0];
                y_ent_d = 1'b1;
            end
        end

        case (state_q)
            S_STOPPED: begin
                if (sw_power) state_d = S_STARTING;
            end
            S_STARTING: begin
                flick_d = flick_q;
                if (flicker_fall) begin
                    if (flick_q == 2'd2) state_d = S_RESET_STATE;
                    else                 flick_d = flick_q + 2'd1;
                end
            end
            S_RESET_STATE: begin
                if (memrst_done) state_d = S_WAIT_INPUT;
            end
            S_WAIT_INPUT: begin
                // A timeout forfeits the move, so it outranks both buttons.
                if (timer_expire) begin
                    side_d  = ~side_q;
                    x_ent_d = 1'b0;
                    y_ent_d = 1'b0;
                    undo_d  = 1'b0;
                end else if (undo_rise && undo_q) begin
                    state_d = S_UNDO;
                end else if (ok_rise && x_ent_q && y_ent_q) begin
                    state_d = S_JUDGE;
                end
            end
            S_JUDGE: begin
                if (judge_done) begin
                    if (judge_result == JUDGER_VALID || judge_result == JUDGER_WIN) begin
                        result_d = judge_result;
                        state_d  = S_WRITE;
                    end else begin
                        x_ent_d = 1'b0;
                        y_ent_d = 1'b0;
                        state_d = S_WAIT_INPUT;
                    end
                end
            end
            S_WRITE: begin
                last_pos_d = cur_pos;
                undo_d     = 1'b1;
                pieces_d   = pieces_q + CB'(1);
                if (result_q == JUDGER_WIN) begin
                    loser_d = ~side_q;
                    if (side_q == SIDE_RED) begin
                        red_d   = red_inc;
                        state_d = (red_inc == MP_VAL) ? S_MATCH_END : S_END;
                    end else begin
                        green_d = green_inc;
                        state_d = (green_inc == MP_VAL) ? S_MATCH_END : S_END;
                    end
                end else if (pieces_q == LAST_CELL) begin
                    state_d = S_END;
                end else begin
                    side_d  = ~side_q;
                    x_ent_d = 1'b0;
                    y_ent_d = 1'b0;
                    state_d = S_WAIT_INPUT;
                end
            end
            S_UNDO: begin
                pieces_d = pieces_q - CB'(1);
                side_d   = ~side_q;
                undo_d   = 1'b0;
                x_ent_d  = 1'b0;
                y_ent_d  = 1'b0;
                state_d  = S_WAIT_INPUT;
            end
            S_END: begin
                if (ok_rise) state_d = S_RESET_STATE;
            end
            S_MATCH_END: begin
                if (ok_rise) begin
                    red_d   = '0;
                    green_d = '0;
                    state_d = S_RESET_STATE;
                end
            end
            default: state_d = S_STOPPED;
        endcase

        if (!sw_power) begin
            state_d = S_STOPPED;
            red_d   = '0;
            green_d = '0;
        end else if (btn_reset && state_q != S_STOPPED) begin
            state_d = S_RESET_STATE;
        end

        if (state_d == S_RESET_STATE) begin
            x_ent_d  = 1'b0;
            y_ent_d  = 1'b0;
            undo_d   = 1'b0;
            pieces_d = '0;
            side_d   = loser_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_STOPPED;
            side_q      <= SIDE_RED;
            loser_q     <= SIDE_RED;
            x_q         <= '0;
            y_q         <= '0;
            x_ent_q     <= 1'b0;
            y_ent_q     <= 1'b0;
            undo_q      <= 1'b0;
            last_pos_q  <= '0;
            pieces_q    <= '0;
            red_q       <= '0;
            green_q     <= '0;
            flick_q     <= 2'd0;
            result_q    <= JUDGER_INVALID;
            ok_prev_q   <= 1'b0;
            undo_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            side_q      <= side_d;
            loser_q     <= loser_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x_ent_q     <= x_ent_d;
            y_ent_q     <= y_ent_d;
            undo_q      <= undo_d;
            last_pos_q  <= last_pos_d;
            pieces_q    <= pieces_d;
            red_q       <= red_d;
            green_q     <= green_d;
            flick_q     <= flick_d;
            result_q    <= result_d;
            ok_prev_q   <= ok_prev_d;
            undo_prev_q <= undo_prev_d;
        end
    end

    // Countdown lives only in WAIT_INPUT/JUDGE and reloads on each entry to WAIT_INPUT.
    assign timer_en   = (state_d == S_WAIT_INPUT) || (state_d == S_JUDGE);
    assign timer_load = (state_d == S_WAIT_INPUT) && (state_q != S_WAIT_INPUT);

    turn_timer #(
        .RELOAD (TURN_SECONDS)
    ) u_turn_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (timer_en),
        .load   (timer_load),
        .tick   (tick),
        .count  (num_countdown),
        .expire (timer_expire)
    );

    assign key_ready    = (state_q == S_WAIT_INPUT);
    assign memrst_en    = (state_q == S_RESET_STATE);
    assign judge_req    = (state_q == S_JUDGE);
    assign match_over   = (state_q == S_MATCH_END);
    assign ram_we       = (state_q == S_WRITE) || (state_q == S_UNDO);
    assign ram_wr_data  = (state_q == S_WRITE) ? side_cell(side_q) : CELL_EMPTY;
    assign pos          = (state_q == S_UNDO) ? last_pos_q : cur_pos;
    assign cursor_valid = x_ent_q & y_ent_q;
    assign active_side  = side_q;
    assign red_wins     = red_q;
    assign green_wins   = green_q;
    assign state_o      = state_q;

endmodule
